// File: rtl/score_pkg.sv
// Shared encodings for the reaction score keeper: FSM states, view codes, blank digit
// and the BCD digit check. Optional worst tracking is controlled by SCORE_WORST_EN.
package score_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WRITE = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [1:0] VIEW_LAST   = 2'd0;
  localparam logic [1:0] VIEW_BEST   = 2'd1;
  localparam logic [1:0] VIEW_WORST  = 2'd2;
  localparam logic [1:0] VIEW_BROWSE = 2'd3;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  // Widest result the digit check accepts; callers zero-extend into this width.
  localparam int BCD_MAX_DIGITS = 8;

  function automatic logic bcd_valid(input logic [4*BCD_MAX_DIGITS-1:0] v, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < n && v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/score_history_buf.sv
// Circular history register file: one write port, one async read port addressed
// relative to the newest entry, with write pointer and saturating entry count.
module score_history_buf #(
  parameter int DATA_W     = 16,
  parameter int HIST_DEPTH = 8,
  parameter int IDX_W      = 3
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W:0]    count
);

  localparam logic [IDX_W:0] FULL = HIST_DEPTH[IDX_W:0];

  logic [DATA_W-1:0] mem [HIST_DEPTH];
  logic [IDX_W-1:0]  wr_ptr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (we) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      if (count != FULL) count <= count + (IDX_W+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (we && !clr) mem[wr_ptr] <= wr_data;
  end

  // Offset 0 is the most recent write; the pointer wraps because depth is a power of two.
  assign rd_data = mem[wr_ptr - IDX_W'(1) - rd_off];

endmodule

// File: rtl/reaction_score_keeper.sv
// Captures finished BCD reaction times, tracks last/best(/worst) and drives a selected
// value to the display stage. Define SCORE_WORST_EN to include the worst-time register.
module reaction_score_keeper
  import score_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int HIST_DEPTH = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  result_valid,
  input  logic [4*N_DIGITS-1:0] result_bcd,
  input  logic                  clear,
  input  logic [1:0]            view_sel,
  input  logic                  browse_step,
  output logic [4*N_DIGITS-1:0] disp_bcd,
  output logic                  disp_valid,
  output logic [IDX_W-1:0]      browse_idx,
  output logic [IDX_W:0]        count,
  output logic                  new_best,
  output logic                  err
);

  localparam int           W     = 4*N_DIGITS;
  localparam logic [W-1:0] BLANK = {N_DIGITS{BLANK_DIGIT}};

  state_t                      state, state_next;
  logic [W-1:0]                pend_p0, last, best, hist_rd, disp_next;
  logic [4*BCD_MAX_DIGITS-1:0] result_ext;
  logic                        digits_ok, accept, write_en, dvalid_next;
  logic [IDX_W:0]              bnext;
`ifdef SCORE_WORST_EN
  logic [W-1:0]                worst;
`endif

  always_comb begin
    result_ext        = '0;
    result_ext[W-1:0] = result_bcd;
  end

  assign digits_ok = bcd_valid(result_ext, N_DIGITS);
  assign accept    = result_valid && !clear && digits_ok && (state != S_WRITE);
  assign write_en  = (state == S_WRITE) && !clear;
  assign bnext     = {1'b0, browse_idx} + (IDX_W+1)'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_next = S_WRITE;
        S_WRITE: state_next = S_READY;
        S_READY: if (accept) state_next = S_WRITE;
        default: state_next = S_EMPTY;
      endcase
    end
  end

  // Stage 0: capture the accepted result for the write cycle
  always_ff @(posedge CLK) begin
    if (accept) pend_p0 <= result_bcd;
  end

  // Stage 1: commit to history and update scores; packed BCD compares like binary
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last       <= BLANK;
      best       <= BLANK;
      browse_idx <= '0;
      new_best   <= 1'b0;
      err        <= 1'b0;
    end else begin
      new_best <= 1'b0;
      err      <= result_valid && !clear && (!digits_ok || state == S_WRITE);
      if (clear) begin
        last       <= BLANK;
        best       <= BLANK;
        browse_idx <= '0;
      end else if (state == S_WRITE) begin
        last       <= pend_p0;
        browse_idx <= '0;
        if (count == '0) begin
          best <= pend_p0;
        end else if (pend_p0 < best) begin
          best     <= pend_p0;
          new_best <= 1'b1;
        end
      end else if (state == S_READY && browse_step && !accept) begin
        browse_idx <= (bnext >= count) ? '0 : bnext[IDX_W-1:0];
      end
    end
  end

`ifdef SCORE_WORST_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      worst <= BLANK;
    end else if (clear) begin
      worst <= BLANK;
    end else if (state == S_WRITE) begin
      if (count == '0 || pend_p0 > worst) worst <= pend_p0;
    end
  end
`endif

  score_history_buf #(
    .DATA_W    (W),
    .HIST_DEPTH(HIST_DEPTH),
    .IDX_W     (IDX_W)
  ) u_hist (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .we     (write_en),
    .clr    (clear),
    .wr_data(pend_p0),
    .rd_off (browse_idx),
    .rd_data(hist_rd),
    .count  (count)
  );

  always_comb begin
    disp_next   = BLANK;
    dvalid_next = 1'b0;
    if (state != S_EMPTY) begin
      dvalid_next = 1'b1;
      case (view_sel)
        VIEW_LAST:   disp_next = last;
        VIEW_BEST:   disp_next = best;
`ifdef SCORE_WORST_EN
        VIEW_WORST:  disp_next = worst;
`else
        VIEW_WORST:  disp_next = last;
`endif
        VIEW_BROWSE: disp_next = hist_rd;
        default:     disp_next = last;
      endcase
    end
  end

  // Stage 2: registered display output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      disp_bcd   <= BLANK;
      disp_valid <= 1'b0;
    end else begin
      disp_bcd   <= disp_next;
      disp_valid <= dvalid_next;
    end
  end

endmodule
